// File: rtl/line_buffer_apb_regbank.sv
// APB3 slave register bank for the line buffer: RW/RO registers, read wait states, PSLVERR, access strobes.
// Optional byte-lane write strobes (pstrb port) when LB_APB_PSTRB_EN is defined.
//
// state  | meaning
// IDLE   | no transfer in flight, waiting for a setup phase
// ACCESS | decode latched, holding access phase until pready completes it
module line_buffer_apb_regbank #(
   parameter int                     NUM_REGS    = 9,
   parameter int                     DEC_W       = 16,
   parameter logic [DEC_W-1:0]       BASE_OFFSET = 'h0010,
   parameter logic [NUM_REGS-1:0]    RO_MASK     = '0,
   parameter logic [NUM_REGS*32-1:0] IMPL_MASK   = {NUM_REGS{32'hFFFF_FFFF}},
   parameter logic [NUM_REGS*32-1:0] RST_VAL     = '0,
   parameter int                     RD_WAIT     = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     psel,
   input  logic                     penable,
   input  logic                     pwrite,
   input  logic [31:0]              paddr,
   input  logic [31:0]              pwdata,
`ifdef LB_APB_PSTRB_EN
   input  logic [3:0]               pstrb,
`endif
   output logic [31:0]              prdata,
   output logic                     pready,
   output logic                     pslverr,
   output logic [NUM_REGS*32-1:0]   reg_q,
   input  logic [NUM_REGS*32-1:0]   ro_d,
   output logic [NUM_REGS-1:0]      wr_pulse,
   output logic [NUM_REGS-1:0]      rd_pulse
);

   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   typedef enum logic {S_IDLE, S_ACCESS} state_t;

   state_t            state, state_d;
   logic              do_setup, do_viol, do_done, do_abort, do_step;

   logic [DEC_W-1:0]  dec_addr, dec_off;
   logic [DEC_W-3:0]  dec_word;
   logic              dec_hit, dec_err;
   logic [IDX_W-1:0]  dec_idx;

   logic [IDX_W-1:0]  acc_idx, rd_idx;
   logic              acc_wr, acc_err;
   logic [2:0]        wait_cnt;

   logic [31:0]       reg_r [NUM_REGS];
   logic [31:0]       rd_val, wr_val, wr_bmask;

   generate
      if (DEC_W < 32) begin : g_upper
         logic unused_paddr_hi;
         assign unused_paddr_hi = ^paddr[31:DEC_W];
      end
   endgenerate

   assign dec_addr = paddr[DEC_W-1:0];
   assign dec_off  = dec_addr - BASE_OFFSET;
   assign dec_word = dec_off[DEC_W-1:2];
   assign dec_idx  = dec_word[IDX_W-1:0];
   assign dec_hit  = (dec_addr >= BASE_OFFSET) && (dec_off[1:0] == 2'b00) &&
                     (32'(dec_word) < NUM_REGS);
   assign dec_err  = !dec_hit || (pwrite && RO_MASK[dec_idx]);

   // Read data is captured at setup (no wait) or at the last wait step.
   assign rd_idx = (state == S_IDLE) ? dec_idx : acc_idx;
   assign rd_val = RO_MASK[rd_idx] ? (ro_d[32*rd_idx +: 32] & IMPL_MASK[32*rd_idx +: 32])
                                   : reg_r[rd_idx];

`ifdef LB_APB_PSTRB_EN
   assign wr_bmask = {{8{pstrb[3]}}, {8{pstrb[2]}}, {8{pstrb[1]}}, {8{pstrb[0]}}};
`else
   assign wr_bmask = '1;
`endif
   assign wr_val = ((reg_r[acc_idx] & ~wr_bmask) | (pwdata & wr_bmask)) &
                   IMPL_MASK[32*acc_idx +: 32];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         S_IDLE:   if (psel) state_d = S_ACCESS;
         S_ACCESS: if (!psel || (penable && pready)) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      do_setup = 1'b0;
      do_viol  = 1'b0;
      do_done  = 1'b0;
      do_abort = 1'b0;
      do_step  = 1'b0;
      case (state)
         S_IDLE: begin
            do_setup = psel && !penable;
            do_viol  = psel && penable;
         end
         S_ACCESS: begin
            if (!psel)        do_abort = 1'b1;
            else if (penable) begin
               do_done = pready;
               do_step = !pready;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_idx  <= '0;
         acc_wr   <= 1'b0;
         acc_err  <= 1'b0;
         wait_cnt <= '0;
         pready   <= 1'b0;
         pslverr  <= 1'b0;
         prdata   <= '0;
         wr_pulse <= '0;
         rd_pulse <= '0;
      end else begin
         wr_pulse <= '0;
         rd_pulse <= '0;
         if (do_setup) begin
            acc_idx  <= dec_idx;
            acc_wr   <= pwrite;
            acc_err  <= dec_err;
            wait_cnt <= 3'(RD_WAIT);
            if (pwrite || dec_err) begin
               pready  <= 1'b1;
               pslverr <= dec_err;
               prdata  <= '0;
            end else begin
               pready  <= (RD_WAIT == 0);
               pslverr <= 1'b0;
               prdata  <= (RD_WAIT == 0) ? rd_val : '0;
            end
         end else if (do_viol) begin
            // Access phase without setup: answer with an error, touch nothing.
            acc_wr  <= 1'b0;
            acc_err <= 1'b1;
            pready  <= 1'b1;
            pslverr <= 1'b1;
            prdata  <= '0;
         end else if (do_step) begin
            wait_cnt <= wait_cnt - 3'd1;
            if (wait_cnt == 3'd1) begin
               pready <= 1'b1;
               prdata <= rd_val;
            end
         end else if (do_done || do_abort) begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
            if (do_done && !acc_err) begin
               if (acc_wr) wr_pulse[acc_idx] <= 1'b1;
               else        rd_pulse[acc_idx] <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++)
            reg_r[i] <= RO_MASK[i] ? 32'h0 : (RST_VAL[32*i +: 32] & IMPL_MASK[32*i +: 32]);
      end else if (do_done && acc_wr && !acc_err) begin
         reg_r[acc_idx] <= wr_val;
      end
   end

   generate
      for (genvar g = 0; g < NUM_REGS; g++) begin : g_regq
         assign reg_q[32*g +: 32] = RO_MASK[g] ? 32'h0 : reg_r[g];
      end
   endgenerate

endmodule

// File: tb/tb_line_buffer_apb_regbank.sv
// Self-checking bench: two register banks (RD_WAIT 0 and 3) against a transfer-level reference model.
`timescale 1ns/1ps
module tb_line_buffer_apb_regbank;

   localparam int NR = 9;
   localparam int CW = NR * 32;
   localparam logic [NR-1:0] P_RO = 9'h100;
   localparam logic [CW-1:0] P_IMPL = {32'h00FF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                       32'h00FF_00FF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                       32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_FFFF};
   localparam logic [CW-1:0] P_RST  = {32'h0BAD_F00D, 32'h7777_7777, 32'h6666_0066,
                                       32'h5555_5555, 32'h4444_4444, 32'h3333_3333,
                                       32'h2222_2222, 32'h1111_1111, 32'hCAFE_0001};

   logic          clk = 1'b0;
   logic          rst;
   logic          psel [2], penable [2], pwrite [2];
   logic [31:0]   paddr [2], pwdata [2], prdata [2];
   logic [3:0]    pstrb [2];
   logic          pready [2], pslverr [2];
   logic [CW-1:0] reg_q [2], ro_d [2];
   logic [NR-1:0] wr_pulse [2], rd_pulse [2];

   int errors = 0;
   int checks = 0;
   logic [31:0] model [2][NR];
   logic [31:0] impl [NR];

   always #5 clk = ~clk;

   line_buffer_apb_regbank #(
      .NUM_REGS(NR), .DEC_W(16), .BASE_OFFSET(16'h0010), .RO_MASK(P_RO),
      .IMPL_MASK(P_IMPL), .RST_VAL(P_RST), .RD_WAIT(0)
   ) u_dut0 (
      .clk(clk), .rst(rst), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
      .paddr(paddr[0]), .pwdata(pwdata[0]),
`ifdef LB_APB_PSTRB_EN
      .pstrb(pstrb[0]),
`endif
      .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]), .reg_q(reg_q[0]),
      .ro_d(ro_d[0]), .wr_pulse(wr_pulse[0]), .rd_pulse(rd_pulse[0])
   );

   line_buffer_apb_regbank #(
      .NUM_REGS(NR), .DEC_W(16), .BASE_OFFSET(16'h0010), .RO_MASK(P_RO),
      .IMPL_MASK(P_IMPL), .RST_VAL(P_RST), .RD_WAIT(3)
   ) u_dut3 (
      .clk(clk), .rst(rst), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
      .paddr(paddr[1]), .pwdata(pwdata[1]),
`ifdef LB_APB_PSTRB_EN
      .pstrb(pstrb[1]),
`endif
      .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]), .reg_q(reg_q[1]),
      .ro_d(ro_d[1]), .wr_pulse(wr_pulse[1]), .rd_pulse(rd_pulse[1])
   );

   task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic int addr_to_idx(input logic [31:0] a);
      int off;
      off = int'(a[15:0]) - 16;
      if (off < 0 || (off % 4) != 0 || (off / 4) >= NR) return -1;
      return off / 4;
   endfunction

   function automatic logic [31:0] strb_mask(input logic [3:0] s);
      logic [31:0] m;
`ifdef LB_APB_PSTRB_EN
      for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{s[k]}};
`else
      m = '1;
`endif
      return m;
   endfunction

   function automatic logic [CW-1:0] exp_regq(input int d);
      logic [CW-1:0] v;
      for (int i = 0; i < NR; i++) v[32*i +: 32] = P_RO[i] ? 32'h0 : model[d][i];
      return v;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < NR; i++)
            model[d][i] = P_RO[i] ? 32'h0 : (P_RST[32*i +: 32] & impl[i]);
   endtask

   // Starts #1 after a rising edge, ends #1 after the completion edge.
   task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] strb, output logic [31:0] rd, output logic er,
                       output int waits);
      bit got;
      psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
      paddr[d] = addr; pwdata[d] = wd; pstrb[d] = strb;
      @(posedge clk); #1;
      penable[d] = 1'b1;
      waits = 0; got = 1'b0; rd = '0; er = 1'b1;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (pready[d] === 1'b1) begin
            got = 1'b1;
            break;
         end
         waits++;
         @(posedge clk); #1;
      end
      chk("pready_timeout", CW'(got), CW'(1));
      if (got) begin
         rd = prdata[d];
         er = pslverr[d];
      end
      @(posedge clk); #1;
      psel[d] = 1'b0; penable[d] = 1'b0;
   endtask

   task automatic run(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] strb);
      int idx, waits, expw;
      logic experr, er;
      logic [31:0] exprd, rd, bm;
      logic [NR-1:0] ewp, erp;
      idx = addr_to_idx(addr);
      experr = (idx < 0);
      if (!experr && wr && P_RO[idx]) experr = 1'b1;
      exprd = '0; ewp = '0; erp = '0; expw = 0;
      if (!experr) begin
         if (wr) ewp[idx] = 1'b1;
         else begin
            erp[idx] = 1'b1;
            exprd = P_RO[idx] ? (ro_d[d][32*idx +: 32] & impl[idx]) : model[d][idx];
            expw  = (d == 1) ? 3 : 0;
         end
      end
      xfer(d, wr, addr, wd, strb, rd, er, waits);
      chk("prdata", CW'(rd), CW'(exprd));
      chk("pslverr", CW'(er), CW'(experr));
      chk("wait_cycles", CW'(waits), CW'(expw));
      chk("wr_pulse", CW'(wr_pulse[d]), CW'(ewp));
      chk("rd_pulse", CW'(rd_pulse[d]), CW'(erp));
      if (!experr && wr) begin
         bm = strb_mask(strb);
         model[d][idx] = ((model[d][idx] & ~bm) | (wd & bm)) & impl[idx];
      end
      chk("reg_q", reg_q[d], exp_regq(d));
   endtask

   function automatic logic [31:0] rnd_addr();
      int r;
      logic [31:0] a;
      r = $urandom_range(0, 11);
      if (r < 9)       a = 32'h10 + 32'(4 * r);
      else if (r == 9) a = 32'h10 + 32'(4 * $urandom_range(0, 8)) + 32'($urandom_range(1, 3));
      else if (r == 10) a = 32'($urandom_range(0, 15));
      else             a = 32'h34 + 32'(4 * $urandom_range(0, 100));
      if ($urandom_range(0, 3) == 0) a[31:16] = 16'($urandom);
      return a;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic er;
      int w;
      for (int i = 0; i < NR; i++) impl[i] = P_IMPL[32*i +: 32];
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
         paddr[d] = '0; pwdata[d] = '0; pstrb[d] = 4'hF;
         for (int i = 0; i < NR; i++) ro_d[d][32*i +: 32] = $urandom;
      end
      model_reset();
      #2;
      for (int d = 0; d < 2; d++) begin
         chk("rst_pready", CW'(pready[d]), CW'(0));
         chk("rst_pslverr", CW'(pslverr[d]), CW'(0));
         chk("rst_prdata", CW'(prdata[d]), CW'(0));
         chk("rst_pulses", CW'({wr_pulse[d], rd_pulse[d]}), CW'(0));
         chk("rst_reg_q", reg_q[d], exp_regq(d));
      end
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Reset values readback, RD_WAIT=0
      for (int i = 0; i < NR; i++) run(0, 1'b0, 32'h10 + 32'(4 * i), '0, 4'hF);

      // Partially implemented register
      run(0, 1'b1, 32'h14, 32'hDEAD_BEEF, 4'hF);
      chk("reg1_slice", CW'(reg_q[0][63:32]), CW'(32'h0000_BEEF));
      @(posedge clk); #1;
      chk("wr_pulse_one_cycle", CW'(wr_pulse[0]), CW'(0));
      run(0, 1'b0, 32'h14, '0, 4'hF);

      // Error responses
      run(0, 1'b1, 32'h30, 32'h1234_5678, 4'hF);
      run(0, 1'b0, 32'h34, '0, 4'hF);
      run(0, 1'b0, 32'h12, '0, 4'hF);
      run(0, 1'b0, 32'h0C, '0, 4'hF);

      // Read wait states
      ro_d[1][32*8 +: 32] = 32'h00AB_CDEF;
      run(1, 1'b0, 32'h30, '0, 4'hF);
      run(1, 1'b1, 32'h1C, 32'h0F0F_1234, 4'hF);
      run(1, 1'b0, 32'h1C, '0, 4'hF);
      run(1, 1'b0, 32'h13, '0, 4'hF);

      // Back-to-back write then read
      run(0, 1'b1, 32'h10, 32'h0000_002A, 4'hF);
      run(0, 1'b0, 32'h10, '0, 4'hF);

      // Access phase without setup
      psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 32'h18; pwdata[0] = 32'h5A5A_5A5A;
      @(posedge clk); @(negedge clk);
      chk("viol_pready", CW'(pready[0]), CW'(1));
      chk("viol_pslverr", CW'(pslverr[0]), CW'(1));
      @(posedge clk); #1;
      psel[0] = 1'b0; penable[0] = 1'b0;
      chk("viol_done_pready", CW'(pready[0]), CW'(0));
      chk("viol_pulses", CW'({wr_pulse[0], rd_pulse[0]}), CW'(0));
      chk("viol_reg_q", reg_q[0], exp_regq(0));

      // psel dropped during access: write on dut0, read on dut3
      psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h18; pwdata[0] = 32'h9999_9999;
      @(posedge clk); #1;
      psel[0] = 1'b0;
      @(posedge clk); #1;
      chk("abort_wr_pready", CW'(pready[0]), CW'(0));
      chk("abort_wr_pulse", CW'(wr_pulse[0]), CW'(0));
      chk("abort_wr_reg_q", reg_q[0], exp_regq(0));
      psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b0; paddr[1] = 32'h20;
      @(posedge clk); #1;
      penable[1] = 1'b1;
      @(posedge clk); #1;
      psel[1] = 1'b0; penable[1] = 1'b0;
      @(posedge clk); #1;
      chk("abort_rd_pready", CW'(pready[1]), CW'(0));
      chk("abort_rd_pulse", CW'(rd_pulse[1]), CW'(0));
      run(1, 1'b0, 32'h20, '0, 4'hF);

`ifdef LB_APB_PSTRB_EN
      run(0, 1'b1, 32'h1C, 32'h1122_3344, 4'hF);
      run(0, 1'b1, 32'h1C, 32'hAABB_CCDD, 4'b0101);
      chk("pstrb_0101", CW'(reg_q[0][32*3 +: 32]), CW'(32'h11BB_33DD));
      run(0, 1'b1, 32'h1C, 32'hFFFF_FFFF, 4'b0000);
      chk("pstrb_none", CW'(reg_q[0][32*3 +: 32]), CW'(32'h11BB_33DD));
`endif

      // Randomized traffic on both banks
      for (int n = 0; n < 80; n++) begin
         int d;
         d = n % 2;
         if ($urandom_range(0, 4) == 0) ro_d[d][32*8 +: 32] = $urandom;
         run(d, 1'($urandom_range(0, 1)), rnd_addr(), $urandom, 4'($urandom_range(0, 15)));
      end

      // Reset during a waiting read
      run(1, 1'b1, 32'h10, 32'hFEED_0BAD, 4'hF);
      psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b0; paddr[1] = 32'h10;
      @(posedge clk); #1;
      penable[1] = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      #1;
      model_reset();
      chk("rst_mid_pready", CW'(pready[1]), CW'(0));
      chk("rst_mid_reg_q1", reg_q[1], exp_regq(1));
      chk("rst_mid_reg_q0", reg_q[0], exp_regq(0));
      psel[1] = 1'b0; penable[1] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run(1, 1'b0, 32'h10, '0, 4'hF);
      xfer(0, 1'b0, 32'h24, '0, 4'hF, rd, er, w);
      chk("post_rst_read", CW'(rd), CW'(P_RST[32*5 +: 32] & P_IMPL[32*5 +: 32]));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
